// File: rtl/native_bus_initiator.sv
// Clocked initiator for the native parallel bus (r_wn / addr / wdata / rdata).
// Takes one request at a time. An address inside either endpoint window is driven
// as a one-cycle setup phase followed by a fixed-length access phase. An address
// outside both windows is answered with an error and causes no bus activity.
`timescale 1ns / 1ps

module native_bus_initiator #(
  parameter int unsigned ADDR_WIDTH  = 5,
  parameter int unsigned DATA_WIDTH  = 4,
  parameter int unsigned BASE0       = 0,
  parameter int unsigned RANGE0      = 4,
  parameter int unsigned BASE1       = 16,
  parameter int unsigned RANGE1      = 8,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  // request port
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_r_wn,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  // response port
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic                  busy,
  // native bus
  output logic                  r_wn,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] wdata,
  input  logic [DATA_WIDTH-1:0] rdata
);

  typedef enum logic [1:0] {StIdle, StSetup, StAccess, StResp} state_e;

  // Window bounds carry one extra bit so that base + range cannot wrap.
  localparam logic [ADDR_WIDTH:0] Lo0 = (ADDR_WIDTH + 1)'(BASE0);
  localparam logic [ADDR_WIDTH:0] Hi0 = (ADDR_WIDTH + 1)'(BASE0 + RANGE0);
  localparam logic [ADDR_WIDTH:0] Lo1 = (ADDR_WIDTH + 1)'(BASE1);
  localparam logic [ADDR_WIDTH:0] Hi1 = (ADDR_WIDTH + 1)'(BASE1 + RANGE1);
  localparam logic [ADDR_WIDTH:0] One = (ADDR_WIDTH + 1)'(1);
  localparam logic [3:0]          LastCnt = 4'(WAIT_CYCLES - 1);

  state_e                state_q;
  logic                  rd_q;
  logic [3:0]            cnt_q;
  logic [ADDR_WIDTH:0]   addr_ext;
  logic [ADDR_WIDTH:0]   addr_inc;
  logic                  addr_ok;

  // Window decode; a >= base is written as a + 1 > base so a zero base is not a
  // constant-true comparison.
  always_comb begin
    addr_ext = {1'b0, req_addr};
    addr_inc = addr_ext + One;
    addr_ok  = ((addr_inc > Lo0) && (addr_ext < Hi0)) ||
               ((addr_inc > Lo1) && (addr_ext < Hi1));
  end

  assign req_ready = (state_q == StIdle);

  // Transaction sequencer with all bus and response outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      rd_q       <= 1'b1;
      cnt_q      <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      busy       <= 1'b0;
      r_wn       <= 1'b1;
      addr       <= '0;
      wdata      <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            busy <= 1'b1;
            rd_q <= req_r_wn;
            if (addr_ok) begin
              addr    <= req_addr;
              wdata   <= req_wdata;
              state_q <= StSetup;
            end else begin
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
              state_q    <= StResp;
            end
          end
        end
        StSetup: begin
          // Direction flips only after address and data have had a full setup cycle.
          cnt_q   <= '0;
          r_wn    <= rd_q;
          state_q <= StAccess;
        end
        StAccess: begin
          if (cnt_q == LastCnt) begin
            r_wn       <= 1'b1;
            addr       <= '0;
            wdata      <= '0;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= rd_q ? rdata : '0;
            state_q    <= StResp;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        StResp: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            busy       <= 1'b0;
            state_q    <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_native_bus_initiator.sv
// Bench for native_bus_initiator: a transaction-timeline reference model checked
// every cycle, an endpoint memory on the bus, directed cases and random traffic.
`timescale 1ns / 1ps

module tb_native_bus_initiator;

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 4;
  localparam int unsigned WC = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready, req_r_wn;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          resp_valid, resp_ready, resp_err, busy;
  logic [DW-1:0] resp_rdata;
  logic          r_wn;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata, rdata;

  int n_chk = 0;
  int n_fail = 0;
  int n_hs = 0;

  always #5 clk = ~clk;

  native_bus_initiator #(
    .ADDR_WIDTH (AW), .DATA_WIDTH (DW), .BASE0 (0), .RANGE0 (4),
    .BASE1 (16), .RANGE1 (8), .WAIT_CYCLES (WC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_r_wn   (req_r_wn),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .busy       (busy),
    .r_wn       (r_wn),
    .addr       (addr),
    .wdata      (wdata),
    .rdata      (rdata)
  );

  function automatic bit in_win(input logic [AW-1:0] a);
    int v;
    v = int'(a);
    return (v >= 0 && v < 4) || (v >= 16 && v < 24);
  endfunction

  function automatic logic [DW-1:0] init_val(input int a);
    return 4'((a * 7 + 3) % 16);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Endpoint memory covering both windows; unwritten locations read init_val.
  logic [DW-1:0] ep_mem [32];
  bit            ep_wr  [32];
  logic          ep_clr;

  always @(posedge clk) begin
    if (ep_clr) begin
      for (int i = 0; i < 32; i++) ep_wr[i] <= 1'b0;
    end else if (!rst && !r_wn && in_win(addr)) begin
      ep_mem[addr] <= wdata;
      ep_wr[addr]  <= 1'b1;
    end
  end

  assign rdata = !in_win(addr) ? '0 : (ep_wr[addr] ? ep_mem[addr] : init_val(int'(addr)));

  // Reference model: time since acceptance decides every output.
  bit            m_busy, m_ok, m_rd;
  int            m_t, m_lat;
  logic [AW-1:0] m_a;
  logic [DW-1:0] m_d, m_rdata;
  logic [DW-1:0] model_mem [32];
  bit            e_rv, e_bus, e_rwn;
  int            rst_events = 0;
  int            rst_seen = 0;

  always @(posedge rst) rst_events++;

  // Compare DUT against the model, then advance the model on the inputs now applied.
  always @(negedge clk) begin
    if (rst || rst_events != rst_seen) begin
      rst_seen = rst_events;
      m_busy = 1'b0;
      m_t    = 0;
      m_ok   = 1'b0;
      m_rd   = 1'b1;
    end
    if (ep_clr) for (int i = 0; i < 32; i++) model_mem[i] = init_val(i);

    m_lat = m_ok ? int'(WC) + 2 : 1;
    e_rv  = m_busy && (m_t >= m_lat);
    e_bus = m_busy && m_ok && (m_t <= int'(WC) + 1);
    e_rwn = !(e_bus && m_t >= 2 && !m_rd);

    chk("req_ready", 32'(req_ready), 32'(!m_busy));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("resp_valid", 32'(resp_valid), 32'(e_rv));
    chk("r_wn", 32'(r_wn), 32'(e_rwn));
    chk("addr", 32'(addr), e_bus ? 32'(m_a) : 0);
    chk("wdata", 32'(wdata), e_bus ? 32'(m_d) : 0);
    if (e_rv || rst) begin
      chk("resp_rdata", 32'(resp_rdata), e_rv ? 32'(m_rdata) : 0);
      chk("resp_err", 32'(resp_err), e_rv ? 32'(!m_ok) : 0);
    end
    if (resp_valid && resp_ready) n_hs++;

    if (!rst) begin
      if (!m_busy) begin
        if (req_valid) begin
          m_busy = 1'b1;
          m_t    = 1;
          m_a    = req_addr;
          m_d    = req_wdata;
          m_rd   = req_r_wn;
          m_ok   = in_win(req_addr);
          m_rdata = '0;
        end
      end else if (m_t >= m_lat) begin
        if (resp_ready) m_busy = 1'b0;
      end else begin
        m_t++;
        if (m_t == int'(WC) + 2) begin
          m_rdata = m_rd ? model_mem[m_a] : '0;
          if (!m_rd) model_mem[m_a] = m_d;
        end
      end
    end
  end

  // One transaction from idle; called just after a rising edge.
  task automatic txn(input bit rd, input logic [AW-1:0] a, input logic [DW-1:0] d,
                     input int hold, output int lat, output int wlow, output int rlow,
                     output logic [DW-1:0] rdv, output bit err);
    lat = 0; wlow = 0; rlow = 0; rdv = '0; err = 1'b0;
    req_valid = 1'b1; req_r_wn = rd; req_addr = a; req_wdata = d;
    resp_ready = (hold == 0);
    @(posedge clk); #2;
    req_valid = 1'b0;
    req_r_wn  = 1'($urandom_range(0, 1));
    req_addr  = 5'($urandom_range(0, 31));
    req_wdata = 4'($urandom_range(0, 15));
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (!req_ready) rlow++;
      if (!r_wn) wlow++;
      if (resp_valid) begin
        lat = k; rdv = resp_rdata; err = resp_err;
        break;
      end
    end
    if (hold > 0) begin
      repeat (hold) @(posedge clk);
      #2;
    end
    resp_ready = 1'b1;
    @(posedge clk); #2;
    resp_ready = 1'b0;
  endtask

  logic [AW-1:0] b_addr [8] = '{5'd0, 5'd3, 5'd16, 5'd23, 5'd4, 5'd17, 5'd31, 5'd16};
  bit            b_rd   [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

  initial begin
    int lat, wlow, rlow, hs0, waited;
    logic [DW-1:0] rdv;
    bit err;

    rst = 1'b1; ep_clr = 1'b1;
    req_valid = 1'b0; req_r_wn = 1'b1; req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("reset_req_ready", 32'(req_ready), 1);
    chk("reset_r_wn", 32'(r_wn), 1);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_resp_valid", 32'(resp_valid), 0);
    rst = 1'b0; ep_clr = 1'b0;
    @(posedge clk); #2;

    // Write then read back.
    txn(1'b0, 5'd2, 4'hA, 0, lat, wlow, rlow, rdv, err);
    chk("wr2_latency", lat, 4);
    chk("wr2_rwn_low_cycles", wlow, 2);
    chk("wr2_req_ready_low", rlow, 4);
    chk("wr2_err", 32'(err), 0);
    chk("wr2_rdata", 32'(rdv), 0);
    txn(1'b1, 5'd2, 4'h0, 0, lat, wlow, rlow, rdv, err);
    chk("rd2_latency", lat, 4);
    chk("rd2_rwn_low_cycles", wlow, 0);
    chk("rd2_rdata", 32'(rdv), 32'hA);
    chk("rd2_err", 32'(err), 0);

    // Window boundaries.
    txn(1'b1, 5'd3, 4'h0, 0, lat, wlow, rlow, rdv, err);
    chk("rd3_err", 32'(err), 0);
    chk("rd3_rdata", 32'(rdv), 32'(init_val(3)));
    txn(1'b1, 5'd23, 4'h0, 0, lat, wlow, rlow, rdv, err);
    chk("rd23_err", 32'(err), 0);
    txn(1'b1, 5'd4, 4'h0, 0, lat, wlow, rlow, rdv, err);
    chk("rd4_err", 32'(err), 1);
    chk("rd4_latency", lat, 1);
    txn(1'b1, 5'd15, 4'h0, 0, lat, wlow, rlow, rdv, err);
    chk("rd15_err", 32'(err), 1);
    txn(1'b0, 5'd24, 4'h7, 0, lat, wlow, rlow, rdv, err);
    chk("wr24_err", 32'(err), 1);
    chk("wr24_latency", lat, 1);
    chk("wr24_no_bus_write", wlow, 0);

    // Response backpressure.
    txn(1'b0, 5'd17, 4'h5, 0, lat, wlow, rlow, rdv, err);
    txn(1'b1, 5'd17, 4'h0, 5, lat, wlow, rlow, rdv, err);
    chk("rd17_rdata", 32'(rdv), 5);
    chk("rd17_held_rdata", 32'(resp_rdata), 0);

    // Reset during the access phase of a write aborts it.
    txn(1'b0, 5'd16, 4'h3, 0, lat, wlow, rlow, rdv, err);
    req_valid = 1'b1; req_r_wn = 1'b0; req_addr = 5'd16; req_wdata = 4'hC; resp_ready = 1'b1;
    @(posedge clk); #2;
    req_valid = 1'b0;
    @(posedge clk); #2;
    chk("abort_pre_r_wn", 32'(r_wn), 0);
    rst = 1'b1;
    #1;
    chk("abort_r_wn", 32'(r_wn), 1);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_resp_valid", 32'(resp_valid), 0);
    #1;
    rst = 1'b0;
    @(posedge clk); #2;
    txn(1'b1, 5'd16, 4'h0, 0, lat, wlow, rlow, rdv, err);
    chk("rd16_after_abort", 32'(rdv), 3);
    chk("rd16_latency", lat, 4);

    // Random traffic.
    for (int c = 0; c < 800; c++) begin
      @(posedge clk); #2;
      req_valid  = 1'($urandom_range(0, 1));
      req_r_wn   = 1'($urandom_range(0, 1));
      req_addr   = 5'($urandom_range(0, 31));
      req_wdata  = 4'($urandom_range(0, 15));
      resp_ready = ($urandom_range(0, 3) != 0);
    end
    req_valid = 1'b0; resp_ready = 1'b1;
    waited = 0;
    while (!req_ready && waited < 30) begin
      @(posedge clk); #2;
      waited++;
    end
    @(posedge clk); #2;

    // Back-to-back requests held valid.
    hs0 = n_hs;
    for (int i = 0; i < 8; i++) begin
      req_valid = 1'b1; req_r_wn = b_rd[i]; req_addr = b_addr[i];
      req_wdata = 4'(i + 9);
      waited = 0;
      do begin
        @(negedge clk);
        waited++;
      end while (!req_ready && waited < 50);
      @(posedge clk); #2;
    end
    req_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    chk("b2b_responses", n_hs - hs0, 8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
